// File: rtl/lector_mem_pkg.sv
// Shared constants for the instruction-memory reader: FSM state codes,
// alignment width and the end-of-program marker shared with program_counter.
package lector_mem_pkg;

    localparam logic [2:0] E_INICIO      = 3'd0;
    localparam logic [2:0] E_PEDIR_BAJO  = 3'd1;
    localparam logic [2:0] E_ESPERA_BAJO = 3'd2;
    localparam logic [2:0] E_PEDIR_ALTO  = 3'd3;
    localparam logic [2:0] E_ESPERA_ALTO = 3'd4;
    localparam logic [2:0] E_ENTREGA     = 3'd5;

    localparam int unsigned ALINEACION_BITS = 2;
    localparam logic [31:0] FIN_PROGRAMA    = 32'hFFFF_FFFF;

endpackage

// File: rtl/lector_memoria_instrucciones_ensamblador_palabra.sv
// Assembles two half-words into one instruction word; the visible word only
// changes when carga_salida_i is asserted, so partial words never leak out.
module ensamblador_palabra
#(
    parameter int unsigned BITS_MITAD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    carga_bajo_i,
    input  logic                    carga_alto_i,
    input  logic                    carga_salida_i,
    input  logic [BITS_MITAD-1:0]   dato_bajo_i,
    input  logic [BITS_MITAD-1:0]   dato_alto_i,
    output logic [2*BITS_MITAD-1:0] palabra_o
);

    logic [BITS_MITAD-1:0]   bajo_q, bajo_d;
    logic [BITS_MITAD-1:0]   alto_q, alto_d;
    logic [2*BITS_MITAD-1:0] palabra_q, palabra_d;

    // Bypass the half being loaded this cycle so the output can load together with it.
    always_comb begin
        bajo_d    = carga_bajo_i ? dato_bajo_i : bajo_q;
        alto_d    = carga_alto_i ? dato_alto_i : alto_q;
        palabra_d = carga_salida_i ? {alto_d, bajo_d} : palabra_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bajo_q    <= '0;
            alto_q    <= '0;
            palabra_q <= '0;
        end else begin
            bajo_q    <= bajo_d;
            alto_q    <= alto_d;
            palabra_q <= palabra_d;
        end
    end

    assign palabra_o = palabra_q;

endmodule

// File: rtl/lector_memoria_instrucciones.sv
// Instruction fetch responder: two 16-bit reads per 32-bit word, little-endian.
// Optional single-entry line cache enabled with macro LECTOR_CACHE_LINEA_EN.
module lector_memoria_instrucciones
    import lector_mem_pkg::*;
#(
    parameter int unsigned BITS_DIRECCION_MEMORIA = 14,
    parameter int unsigned BITS_DATOS_MEM         = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                leer_siguiente_inst,
    input  logic [BITS_DIRECCION_MEMORIA-1:0]   direccion_siguiente_inst,
    output logic                                mem_leer,
    output logic [BITS_DIRECCION_MEMORIA-2:0]   mem_direccion,
    input  logic [BITS_DATOS_MEM-1:0]           mem_dato,
    input  logic                                mem_dato_valido,
    output logic [2*BITS_DATOS_MEM-1:0]         instruccion_actual,
    output logic                                lectura_completada,
    output logic                                error_alineacion,
    output logic                                ocupado
);

    localparam int unsigned TAMANO_INSTRUCCION = 2 * BITS_DATOS_MEM;
    localparam int unsigned BITS_DIR_REG       = BITS_DIRECCION_MEMORIA - ALINEACION_BITS;

    logic [2:0]                          estado_q, estado_d;
    logic [BITS_DIR_REG-1:0]             dir_q, dir_d;
    logic                                error_q, error_d;
    logic                                mem_leer_q, mem_leer_d;
    logic [BITS_DIRECCION_MEMORIA-2:0]   mem_dir_q, mem_dir_d;
    logic                                completada_q, completada_d;
    logic                                ocupado_q, ocupado_d;
    logic                                carga_bajo_c, carga_alto_c, carga_salida_c;
    logic [BITS_DATOS_MEM-1:0]           dato_bajo_c, dato_alto_c;

`ifdef LECTOR_CACHE_LINEA_EN
    logic [BITS_DIR_REG-1:0]             cache_tag_q;
    logic                                cache_valido_q;
    logic [TAMANO_INSTRUCCION-1:0]       cache_dato_q;
    logic                                acierto_c;

    assign acierto_c = cache_valido_q &&
        (cache_tag_q == direccion_siguiente_inst[BITS_DIRECCION_MEMORIA-1:ALINEACION_BITS]);

    // The assembled word is already on instruccion_actual during E_ENTREGA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_tag_q    <= '0;
            cache_valido_q <= 1'b0;
            cache_dato_q   <= '0;
        end else if (estado_q == E_ENTREGA) begin
            cache_tag_q    <= dir_q;
            cache_valido_q <= 1'b1;
            cache_dato_q   <= instruccion_actual;
        end
    end
`endif

    always_comb begin
        estado_d     = estado_q;
        dir_d        = dir_q;
        error_d      = error_q;
        carga_bajo_c = 1'b0;
        carga_alto_c = 1'b0;
        dato_bajo_c  = mem_dato;
        dato_alto_c  = mem_dato;
        case (estado_q)
            E_INICIO: begin
                if (leer_siguiente_inst) begin
                    dir_d    = direccion_siguiente_inst[BITS_DIRECCION_MEMORIA-1:ALINEACION_BITS];
                    estado_d = E_PEDIR_BAJO;
                    if (direccion_siguiente_inst[ALINEACION_BITS-1:0] != '0) begin
                        error_d = 1'b1;
                    end
`ifdef LECTOR_CACHE_LINEA_EN
                    if (acierto_c) begin
                        estado_d     = E_ENTREGA;
                        carga_bajo_c = 1'b1;
                        carga_alto_c = 1'b1;
                        dato_bajo_c  = cache_dato_q[BITS_DATOS_MEM-1:0];
                        dato_alto_c  = cache_dato_q[TAMANO_INSTRUCCION-1:BITS_DATOS_MEM];
                    end
`endif
                end
            end
            E_PEDIR_BAJO:  estado_d = E_ESPERA_BAJO;
            E_ESPERA_BAJO: begin
                if (mem_dato_valido) begin
                    carga_bajo_c = 1'b1;
                    estado_d     = E_PEDIR_ALTO;
                end
            end
            E_PEDIR_ALTO:  estado_d = E_ESPERA_ALTO;
            E_ESPERA_ALTO: begin
                if (mem_dato_valido) begin
                    carga_alto_c = 1'b1;
                    estado_d     = E_ENTREGA;
                end
            end
            E_ENTREGA:     estado_d = E_INICIO;
            default:       estado_d = E_INICIO;
        endcase

        // Outputs are registered from the next state so they line up with it.
        mem_leer_d     = (estado_d == E_PEDIR_BAJO) || (estado_d == E_PEDIR_ALTO);
        mem_dir_d      = mem_leer_d ? {dir_d, (estado_d == E_PEDIR_ALTO)} : mem_dir_q;
        completada_d   = (estado_d == E_ENTREGA);
        carga_salida_c = completada_d;
        ocupado_d      = (estado_d != E_INICIO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q     <= E_INICIO;
            dir_q        <= '0;
            error_q      <= 1'b0;
            mem_leer_q   <= 1'b0;
            mem_dir_q    <= '0;
            completada_q <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            dir_q        <= dir_d;
            error_q      <= error_d;
            mem_leer_q   <= mem_leer_d;
            mem_dir_q    <= mem_dir_d;
            completada_q <= completada_d;
            ocupado_q    <= ocupado_d;
        end
    end

    ensamblador_palabra #(
        .BITS_MITAD (BITS_DATOS_MEM)
    ) u_ensamblador (
        .clk            (clk),
        .rst_n          (reset),
        .carga_bajo_i   (carga_bajo_c),
        .carga_alto_i   (carga_alto_c),
        .carga_salida_i (carga_salida_c),
        .dato_bajo_i    (dato_bajo_c),
        .dato_alto_i    (dato_alto_c),
        .palabra_o      (instruccion_actual)
    );

    assign mem_leer           = mem_leer_q;
    assign mem_direccion      = mem_dir_q;
    assign lectura_completada = completada_q;
    assign error_alineacion   = error_q;
    assign ocupado            = ocupado_q;

endmodule

// File: tb/tb_lector_memoria_instrucciones.sv
// Self-checking bench for lector_memoria_instrucciones with a variable-latency
// memory responder and a word-level reference model (cache-aware when enabled).
module tb_lector_memoria_instrucciones;

    logic        clk;
    logic        reset;
    logic        leer_siguiente_inst;
    logic [13:0] direccion_siguiente_inst;
    logic        mem_leer;
    logic [12:0] mem_direccion;
    logic [15:0] mem_dato;
    logic        mem_dato_valido;
    logic [31:0] instruccion_actual;
    logic        lectura_completada;
    logic        error_alineacion;
    logic        ocupado;

    lector_memoria_instrucciones dut (
        .clk                      (clk),
        .reset                    (reset),
        .leer_siguiente_inst      (leer_siguiente_inst),
        .direccion_siguiente_inst (direccion_siguiente_inst),
        .mem_leer                 (mem_leer),
        .mem_direccion            (mem_direccion),
        .mem_dato                 (mem_dato),
        .mem_dato_valido          (mem_dato_valido),
        .instruccion_actual       (instruccion_actual),
        .lectura_completada       (lectura_completada),
        .error_alineacion         (error_alineacion),
        .ocupado                  (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state
    logic [15:0] mem_arr [8192];
    bit          err_model = 1'b0;
    bit          c_valid   = 1'b0;
    logic [11:0] c_tag     = '0;

    // Memory responder configuration and observation
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          leer_total = 0;
    int          comp_total = 0;
    int          spur_req = 0;
    int          spur_done = 0;
    logic [12:0] addr_hist [256];
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [12:0] p_addr = '0;

    initial begin
        mem_dato_valido = 1'b0;
        mem_dato        = '0;
    end

    always @(negedge clk) begin
        mem_dato_valido = 1'b0;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    pend            = 1'b0;
                    mem_dato_valido = 1'b1;
                    mem_dato        = mem_arr[p_addr];
                end
            end else if (spur_req != spur_done) begin
                spur_done       = spur_done + 1;
                mem_dato_valido = 1'b1;
                mem_dato        = 16'h5A5A;
            end
            if (mem_leer) begin
                addr_hist[leer_total % 256] = mem_direccion;
                leer_total = leer_total + 1;
                pend       = 1'b1;
                p_addr     = mem_direccion;
                cnt        = mem_direccion[0] ? lat_hi : lat_lo;
            end
        end
        if (lectura_completada) comp_total = comp_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        err_model = 1'b0;
        c_valid   = 1'b0;
    endtask

    // One fetch with per-half latencies; optionally injects an ignored request while busy.
    task automatic txn(input logic [13:0] a, input int l1, input int l2,
                       input bit intruso, input logic [13:0] a_intr);
        int          k;
        int          start;
        bit          hit;
        int          exp_lat;
        logic [11:0] base;
        logic [31:0] exp_w;
        base   = a[13:2];
        exp_w  = {mem_arr[{base, 1'b1}], mem_arr[{base, 1'b0}]};
        hit    = 1'b0;
`ifdef LECTOR_CACHE_LINEA_EN
        hit    = c_valid && (c_tag == base);
`endif
        exp_lat = hit ? 1 : 3 + l1 + l2;
        if (a[1:0] != 2'b00) err_model = 1'b1;
        lat_lo = l1;
        lat_hi = l2;
        start  = leer_total;
        @(negedge clk);
        leer_siguiente_inst      = 1'b1;
        direccion_siguiente_inst = a;
        @(negedge clk);
        leer_siguiente_inst = 1'b0;
        k = 0;
        while (!lectura_completada && k < 200) begin
            if (intruso && k == 2) begin
                leer_siguiente_inst      = 1'b1;
                direccion_siguiente_inst = a_intr;
            end else begin
                leer_siguiente_inst = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        leer_siguiente_inst = 1'b0;
        chk($sformatf("latency@%h", a), 32'(k + 1), 32'(exp_lat));
        chk($sformatf("word@%h", a), instruccion_actual, exp_w);
        chk($sformatf("busy_in_entrega@%h", a), 32'(ocupado), 32'd1);
        chk($sformatf("mem_leer_count@%h", a), 32'(leer_total - start), hit ? 32'd0 : 32'd2);
        if (!hit) begin
            chk($sformatf("addr_lo@%h", a), 32'(addr_hist[start % 256]), 32'({base, 1'b0}));
            chk($sformatf("addr_hi@%h", a), 32'(addr_hist[(start + 1) % 256]), 32'({base, 1'b1}));
            c_valid = 1'b1;
            c_tag   = base;
        end
        chk($sformatf("error@%h", a), 32'(error_alineacion), 32'(err_model));
        @(negedge clk);
        chk($sformatf("pulse_single@%h", a), 32'(lectura_completada), 32'd0);
        chk($sformatf("idle_after@%h", a), 32'(ocupado), 32'd0);
        chk($sformatf("word_held@%h", a), instruccion_actual, exp_w);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_leer"}, 32'(mem_leer), 32'd0);
        chk({tag, "_mem_dir"}, 32'(mem_direccion), 32'd0);
        chk({tag, "_instr"}, instruccion_actual, 32'd0);
        chk({tag, "_compl"}, 32'(lectura_completada), 32'd0);
        chk({tag, "_error"}, 32'(error_alineacion), 32'd0);
        chk({tag, "_busy"}, 32'(ocupado), 32'd0);
    endtask

    initial begin
        int          snap;
        logic [31:0] w_snap;
        logic [13:0] ra;
        for (int i = 0; i < 8192; i++) mem_arr[i] = 16'($urandom);
        mem_arr[8] = 16'hBEEF;
        mem_arr[9] = 16'hDEAD;

        reset                    = 1'b0;
        leer_siguiente_inst      = 1'b0;
        direccion_siguiente_inst = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic aligned fetch, 1-cycle memory
        txn(14'h0010, 1, 1, 1'b0, '0);
        // Last aligned address, slow memory
        txn(14'h3FFC, 3, 7, 1'b0, '0);
        // Misaligned request while busy is ignored, as is a stray valid when idle
        txn(14'h0100, 5, 1, 1'b1, 14'h0205);
        #1;
        snap   = comp_total;
        w_snap = instruccion_actual;
        spur_req = spur_req + 1;
        repeat (4) @(negedge clk);
        #1;
        chk("spurious_no_pulse", 32'(comp_total), 32'(snap));
        chk("spurious_word", instruccion_actual, w_snap);
        chk("spurious_idle", 32'(ocupado), 32'd0);
        // Misaligned accepted request: fetch aligned, sticky error
        txn(14'h0013, 1, 1, 1'b0, '0);
        txn(14'h0200, 2, 1, 1'b0, '0);

        // Reset during the high-half wait
        lat_lo = 1;
        lat_hi = 20;
        @(negedge clk);
        leer_siguiente_inst      = 1'b1;
        direccion_siguiente_inst = 14'h0040;
        @(negedge clk);
        leer_siguiente_inst = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_abort_busy", 32'(ocupado), 32'd1);
        #1;
        snap  = comp_total;
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        err_model = 1'b0;
        c_valid   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_no_pulse", 32'(comp_total), 32'(snap));
        txn(14'h0040, 1, 1, 1'b0, '0);

        // Randomized fetches
        for (int t = 0; t < 20; t++) begin
            ra = 14'($urandom);
            if (t % 4 == 0) ra = 14'h0040;
            txn(ra, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0, '0);
        end

        // Back-to-back reads of the same line from a cold start
        do_reset();
        txn(14'h0020, 1, 1, 1'b0, '0);
        txn(14'h0020, 1, 1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
